// File: rtl/cci_mpf_prim_byteena_wr_coalesce.sv
// Coalesces byte-masked writes to one line into a single masked RAM write.
// Optional counters stat_merges/stat_commits: define CCI_MPF_WR_COALESCE_STATS_EN.
module cci_mpf_prim_byteena_wr_coalesce #(
   parameter int N_ENTRIES = 32,
   parameter int N_DATA_BITS = 64,
   parameter int N_BYTE_BITS = 8,
   parameter int MAX_AGE = 15,
   localparam int N_BYTES = N_DATA_BITS / N_BYTE_BITS,
   localparam int AW = $clog2(N_ENTRIES)
) (
   input  logic                   clk0,
   input  logic                   reset,
   input  logic                   ram_rdy,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AW-1:0]          in_addr,
   input  logic [N_BYTES-1:0]     in_byteena,
   input  logic [N_DATA_BITS-1:0] in_wdata,
   input  logic                   flush,
   output logic                   idle,
   input  logic [AW-1:0]          rd_chk_addr,
   output logic                   rd_hazard,
   output logic                   ram_wen,
   output logic [AW-1:0]          ram_addr,
   output logic [N_BYTES-1:0]     ram_byteena,
`ifdef CCI_MPF_WR_COALESCE_STATS_EN
   output logic [31:0]            stat_merges,
   output logic [31:0]            stat_commits,
`endif
   output logic [N_DATA_BITS-1:0] ram_wdata
);

   localparam int AGE_W = (MAX_AGE > 0) ? $clog2(MAX_AGE + 1) : 1;
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_AGE);

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t state_q, state_d;
   logic [AW-1:0] p_addr_q, p_addr_d;
   logic [N_BYTES-1:0] p_mask_q, p_mask_d;
   logic [N_DATA_BITS-1:0] p_data_q, p_data_d;
   logic [AGE_W-1:0] age_q, age_d;
   logic wen_q, wen_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [N_BYTES-1:0] wbe_q, wbe_d;
   logic [N_DATA_BITS-1:0] wdata_q, wdata_d;

   logic accept;
   logic merge_hit;
   logic aged;
   logic [N_BYTES-1:0] m_mask;
   logic [N_DATA_BITS-1:0] m_data;

   assign in_ready = ram_rdy & ~flush & ~reset;
   assign accept = in_valid & in_ready;
   assign aged = (age_q == AGE_MAX);
   assign m_mask = p_mask_q | in_byteena;

   always_comb begin
      m_data = p_data_q;
      for (int b = 0; b < N_BYTES; b++) begin
         if (in_byteena[b])
            m_data[b*N_BYTE_BITS +: N_BYTE_BITS] =
               in_wdata[b*N_BYTE_BITS +: N_BYTE_BITS];
      end
   end

   always_comb begin
      state_d = state_q;
      p_addr_d = p_addr_q;
      p_mask_d = p_mask_q;
      p_data_d = p_data_q;
      age_d = age_q;
      wen_d = 1'b0;
      waddr_d = waddr_q;
      wbe_d = wbe_q;
      wdata_d = wdata_q;
      merge_hit = 1'b0;
      if (ram_rdy) begin
         unique case (state_q)
            EMPTY: begin
               if (accept && (|in_byteena)) begin
                  state_d = HOLD;
                  p_addr_d = in_addr;
                  p_mask_d = in_byteena;
                  p_data_d = in_wdata;
                  age_d = '0;
               end
            end
            HOLD: begin
               if (accept && (in_addr == p_addr_q)) begin
                  merge_hit = 1'b1;
                  p_mask_d = m_mask;
                  p_data_d = m_data;
                  age_d = '0;
                  if ((&m_mask) || aged) begin
                     wen_d = 1'b1;
                     waddr_d = p_addr_q;
                     wbe_d = m_mask;
                     wdata_d = m_data;
                     state_d = EMPTY;
                  end
               end else if (accept) begin
                  wen_d = 1'b1;
                  waddr_d = p_addr_q;
                  wbe_d = p_mask_q;
                  wdata_d = p_data_q;
                  // A zero-mask replacement carries nothing to hold
                  state_d = (|in_byteena) ? HOLD : EMPTY;
                  p_addr_d = in_addr;
                  p_mask_d = in_byteena;
                  p_data_d = in_wdata;
                  age_d = '0;
               end else if (flush || (&p_mask_q) || aged) begin
                  wen_d = 1'b1;
                  waddr_d = p_addr_q;
                  wbe_d = p_mask_q;
                  wdata_d = p_data_q;
                  state_d = EMPTY;
               end else begin
                  age_d = age_q + AGE_W'(1);
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk0) begin
      if (reset) begin
         state_q <= EMPTY;
         p_addr_q <= '0;
         p_mask_q <= '0;
         p_data_q <= '0;
         age_q <= '0;
         wen_q <= 1'b0;
         waddr_q <= '0;
         wbe_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         p_addr_q <= p_addr_d;
         p_mask_q <= p_mask_d;
         p_data_q <= p_data_d;
         age_q <= age_d;
         wen_q <= wen_d;
         waddr_q <= waddr_d;
         wbe_q <= wbe_d;
         wdata_q <= wdata_d;
      end
   end

   assign ram_wen = wen_q;
   assign ram_addr = waddr_q;
   assign ram_byteena = wbe_q;
   assign ram_wdata = wdata_q;

   assign idle = (state_q == EMPTY) & ~wen_q;
   assign rd_hazard = ((state_q == HOLD) && (rd_chk_addr == p_addr_q)) ||
                      (wen_q && (rd_chk_addr == waddr_q));

`ifdef CCI_MPF_WR_COALESCE_STATS_EN
   logic [31:0] merges_q, commits_q;

   always_ff @(posedge clk0) begin
      if (reset) begin
         merges_q <= '0;
         commits_q <= '0;
      end else begin
         if (merge_hit) merges_q <= merges_q + 32'd1;
         if (wen_d) commits_q <= commits_q + 32'd1;
      end
   end

   assign stat_merges = merges_q;
   assign stat_commits = commits_q;
`endif

endmodule
